// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out stage.
// Imported by piso_serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEF = 1'b0;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with a one-word holding register.
// Feeds sequence detectors one bit per clock.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             fstart_q;
  logic             accept;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign accept  = load_valid & ~hold_full;
  assign out_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign shifted = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      fstart_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= din;
            bit_cnt  <= '0;
            state    <= SHIFT;
            fstart_q <= 1'b1;
          end
        end
        SHIFT: begin
          unique case (1'b1)
            (bit_cnt != LAST): begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
              end
            end
            // Last bit on the wire: chain the next word with no bubble.
            (bit_cnt == LAST && hold_full): begin
              shreg     <= hold;
              hold_full <= 1'b0;
              bit_cnt   <= '0;
              fstart_q  <= 1'b1;
            end
            (bit_cnt == LAST && !hold_full && accept): begin
              shreg    <= din;
              bit_cnt  <= '0;
              fstart_q <= 1'b1;
            end
            default: begin
              state   <= IDLE;
              bit_cnt <= '0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready  = ~hold_full;
  assign sout_valid  = (state == SHIFT);
  assign sout        = (state == SHIFT) ? out_bit : IDLE_BIT;
  assign frame_start = fstart_q;
  assign busy        = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB-first and LSB-first
// instances, the latter driving a small 101 detector).
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sout, sout_valid, frame_start, busy;

  logic [W-1:0] din2 = '0;
  logic         lv2 = 1'b0;
  logic         load_ready2, sout2, sout_valid2, frame_start2, busy2;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .load_valid(lv2),
    .load_ready(load_ready2), .sout(sout2), .sout_valid(sout_valid2),
    .frame_start(frame_start2), .busy(busy2)
  );

  // Reference 101 detector on the LSB-first stream.
  logic [2:0] hist;
  logic       det;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      det  <= 1'b0;
    end else begin
      det <= sout_valid2 && ({hist[1:0], sout2} == 3'b101);
      if (sout_valid2) hist <= {hist[1:0], sout2};
    end
  end

  typedef struct packed {
    logic b;
    logic first;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   last_wait = 0;

  always @(negedge clk) begin
    checks++;
    if (sout_valid) begin
      run_len++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: sout=%b but no bit expected", sout);
      end else begin
        e = sb.pop_front();
        if (sout !== e.b || frame_start !== e.first) begin
          errors++;
          $display("FAIL stream_bit: sout=%b fs=%b, expected sout=%b fs=%b",
                   sout, frame_start, e.b, e.first);
        end
      end
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
      if (sout !== 1'b0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL idle_level: sout=%b fs=%b, expected 0 0",
                 sout, frame_start);
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    din = w;
    load_valid = 1'b1;
    while (load_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL send_timeout: load_ready=%b, expected 1", load_ready);
    end
    for (int i = 0; i < W; i++)
      sb.push_back('{b: w[W-1-i], first: logic'(i == 0)});
    last_wait = n;
    @(posedge clk);
  endtask

  task automatic stop_in();
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sout_valid) && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d bits pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (sout !== 1'b0 || sout_valid !== 1'b0 || frame_start !== 1'b0 ||
        busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: s=%b v=%b fs=%b b=%b r=%b, expected 0 0 0 0 1",
               sout, sout_valid, frame_start, busy, load_ready);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: busy=%b ready=%b, expected 0 1",
               busy, load_ready);
    end
  endtask

  task automatic test_single();
    int n;
    send(8'hA5);
    stop_in();
    wait_idle(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL busy_drop: busy fell after %0d cycles, expected 8", n);
    end
    checks++;
    if (last_run != 8) begin
      errors++;
      $display("FAIL single_run: %0d valid cycles, expected 8", last_run);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    send(8'hA5);
    send(8'h3C);
    stop_in();
    wait_idle(n);
    checks++;
    if (last_run != 16) begin
      errors++;
      $display("FAIL b2b_run: %0d valid cycles, expected 16", last_run);
    end
  endtask

  task automatic test_three();
    int n;
    send(8'h96);
    send(8'h0F);
    send(8'hE1);
    checks++;
    if (last_wait != 7) begin
      errors++;
      $display("FAIL backpressure: ready after %0d cycles, expected 7",
               last_wait);
    end
    stop_in();
    wait_idle(n);
    checks++;
    if (last_run != 24) begin
      errors++;
      $display("FAIL three_run: %0d valid cycles, expected 24", last_run);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(8'hFF);
    stop_in();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (sout !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 ||
        load_ready !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: s=%b v=%b b=%b r=%b fs=%b, expected 0 0 0 1 0",
               sout, sout_valid, busy, load_ready, frame_start);
    end
    sb.delete();
    din = 8'hAA;
    load_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_load: busy=%b v=%b, expected 0 0",
               busy, sout_valid);
    end
    load_valid = 1'b0;
    #2 rst = 1'b1;
    send(8'h05);
    stop_in();
    wait_idle(n);
    checks++;
    if (last_run != 8) begin
      errors++;
      $display("FAIL after_reset_run: %0d valid cycles, expected 8", last_run);
    end
  endtask

  task automatic test_lsb_detector();
    logic [W-1:0] w;
    logic [W-1:0] got;
    int           nb;
    int           rises;
    int           rise_at;
    logic         det_prev;
    w = 8'h05;
    got = '0;
    nb = 0;
    rises = 0;
    rise_at = -1;
    det_prev = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_idle: ready=%b busy=%b, expected 1 0",
               load_ready2, busy2);
    end
    din2 = w;
    lv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lv2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        checks++;
        if (frame_start2 !== 1'b1) begin
          errors++;
          $display("FAIL lsb_frame_start: fs=%b, expected 1", frame_start2);
        end
      end
      if (sout_valid2 && nb < W) begin
        got[nb] = sout2;
        nb++;
      end
      if (det && !det_prev) begin
        rises++;
        rise_at = k;
      end
      det_prev = det;
      @(negedge clk);
    end
    checks++;
    if (nb != W) begin
      errors++;
      $display("FAIL lsb_count: %0d bits, expected %0d", nb, W);
    end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (got[i] !== w[i]) begin
        errors++;
        $display("FAIL lsb_bit%0d: got %b, expected %b", i, got[i], w[i]);
      end
    end
    checks++;
    if (rises != 1 || rise_at != 4) begin
      errors++;
      $display("FAIL detector: %0d rises at cycle %0d, expected 1 at 4",
               rises, rise_at);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_three();
    test_reset_mid();
    test_lsb_detector();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out stage that feeds bit streams into the sequence-detector FSMs; its sout drives a detector's I input, one bit per clk.
It accepts WIDTH-bit words over a valid/ready handshake and shifts them out at one bit per cycle.
A one-entry holding register lets back-to-back words stream with no idle bubble between frames.
When no word is pending it drives IDLE_BIT, so the downstream detector sees a defined level.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first.
IDLE_BIT, 1'b0, level driven on sout while sout_valid = 0.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
din  input  WIDTH  parallel word to send.
load_valid  input  1  din is valid this cycle.
load_ready  output  1  block can accept a word; equals ~hold_full.
sout  output  1  serial bit to the downstream detector's I input.
sout_valid  output  1  sout carries a data bit this cycle.
frame_start  output  1  high during the cycle sout carries the first bit of a word.
busy  output  1  frame in flight or word held; equals (state == SHIFT) | hold_full.

Behaviour:
- All outputs decode from registers only; there is no combinational path from din or load_valid to any output.
- Reset (rst = 0, asynchronous, effective immediately, mid-frame included):
  - state = IDLE, bit_cnt = 0, hold_full = 0, shift and hold registers cleared.
  - sout = IDLE_BIT, sout_valid = 0, frame_start = 0, busy = 0, load_ready = 1.
  - Any frame in flight and any held word are discarded. load_valid is ignored while rst = 0.
- A transfer ("accept") happens on a rising edge with load_valid & load_ready.
- States are IDLE and SHIFT. bit_cnt is $clog2(WIDTH) bits and counts 0..WIDTH-1.
- IDLE + accept:
  - Load din into the shift register, bit_cnt = 0, go to SHIFT.
  - The first bit appears on sout in the next cycle (latency 1 cycle from the accepting edge), with sout_valid = 1 and frame_start = 1.
- SHIFT, bit_cnt < WIDTH-1:
  - Each edge shifts the register by one position toward the output end and increments bit_cnt.
  - An accept on this edge writes din to the hold register and sets hold_full.
- SHIFT, bit_cnt == WIDTH-1 (last bit on sout this cycle):
  - hold_full = 1 (no accept is possible, since load_ready = 0): move hold into the shift register, bit_cnt = 0, clear hold_full. Next cycle frame_start = 1.
  - hold_full = 0 with an accept on this edge: load din directly into the shift register (bypass), bit_cnt = 0. Next cycle frame_start = 1.
  - hold_full = 0 with no accept: go to IDLE. Next cycle sout = IDLE_BIT and sout_valid = 0.
- Back-to-back words produce contiguous sout_valid with no gap. Each word occupies exactly WIDTH consecutive valid cycles.
- sout = output end of the shift register while in SHIFT, else IDLE_BIT. sout_valid = (state == SHIFT).
- Backpressure: with one frame shifting and one word held, load_ready = 0. It returns to 1 in the cycle after the held word moves into the shift register.

Decomposition:
- Shared package piso_pkg holds:
  - state enum {IDLE, SHIFT};
  - the CNT_W = $clog2(WIDTH) helper;
  - the default IDLE_BIT constant.
- Single module with no sub-module. The hold register is one always block and does not justify its own module.

Test Plan:
- Reset release, then din = 8'hA5 for one cycle → sout = 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; sout_valid high for exactly 8 cycles; frame_start high on the first; busy drops after the last bit.
- 8'hA5 accepted, then 8'h3C presented while the first frame shifts → 16 contiguous sout_valid cycles; frame_start high in cycles 1 and 9; second frame = 0,0,1,1,1,1,0,0.
- Three words presented back-to-back → load_ready = 0 while the hold register is full; the third word is accepted only after the second enters the shift register; all 24 bits arrive in order with no gap.
- rst = 0 asserted during bit 3 of a frame → sout = IDLE_BIT and sout_valid = 0 immediately, without waiting for an edge; after release, 8'h05 streams cleanly as 0,0,0,0,0,1,0,1.
- MSB_FIRST = 0, din = 8'h05, sout wired to a 101 detector's I → bits 1,0,1,0,0,0,0,0; detector output rises once, one cycle after the third bit is sampled.
